// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register:
// state encoding and small state-decode helpers.
package pipe_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is never written; the decode helpers below treat it as EMPTY.
    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } pipe_state_e;

    // True when the main slot holds a live entry.
    function automatic logic st_holds(input pipe_state_e s);
        logic r;
        case (s)
            ST_FULL: r = 1'b1;
            ST_SKID: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // True when the stage can take a new entry (skid slot free).
    function automatic logic st_accepts(input pipe_state_e s);
        logic r;
        case (s)
            ST_SKID: r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dff.sv
// Basic load-enabled flop bank with synchronous active-low reset.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise capture d when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_slot.sv
// One buffer slot holding a datapath bundle plus its control bundle.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic [DATA_W+CTRL_W-1:0] slot_d_s;
    logic [DATA_W+CTRL_W-1:0] slot_q_s;

    assign slot_d_s = {in_data, in_ctrl};
    assign out_data = slot_q_s[DATA_W+CTRL_W-1:CTRL_W];
    assign out_ctrl = slot_q_s[CTRL_W-1:0];

    dff #(.W(DATA_W + CTRL_W)) u_bank (
        .clk (clk),
        .rst (rst),
        .en  (load),
        .d   (slot_d_s),
        .q   (slot_q_s)
    );

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main + skid slot behind a valid/ready
// handshake, with registered in_ready, flush, bubble ctrl masking and a
// saturating downstream-stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_e       state_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              main_load_s;
    logic              skid_load_s;
    logic              main_from_skid_s;
    logic [DATA_W-1:0] main_d_data_s;
    logic [CTRL_W-1:0] main_d_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [CTRL_W-1:0] skid_ctrl_s;

    // Handshake flags decode purely from the state register.
    assign in_ready_s  = st_accepts(state_r);
    assign out_valid_s = st_holds(state_r);
    assign in_xfer_s   = in_valid & in_ready_s;
    assign out_xfer_s  = out_valid_s & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = main_data_s;
    // An empty slot must never present live control bits downstream.
    assign out_ctrl  = main_ctrl_s & {CTRL_W{out_valid_s}};
    assign stall_cnt = stall_cnt_r;

    // Slot load enables and main-slot source select for this edge.
    always_comb begin
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            main_load_s      = 1'b0;
            skid_load_s      = 1'b0;
            main_from_skid_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    main_load_s = in_valid;
                end
                ST_FULL: begin
                    main_load_s = in_xfer_s & out_xfer_s;
                    skid_load_s = in_xfer_s & ~out_xfer_s;
                end
                ST_SKID: begin
                    main_load_s      = out_ready;
                    main_from_skid_s = 1'b1;
                end
                default: begin
                    main_load_s = in_valid;
                end
            endcase
        end
    end

    // Main slot input: the skid entry when draining it, else upstream.
    always_comb begin
        if (main_from_skid_s) begin
            main_d_data_s = skid_data_s;
            main_d_ctrl_s = skid_ctrl_s;
        end else begin
            main_d_data_s = in_data;
            main_d_ctrl_s = in_ctrl;
        end
    end

    // Occupancy FSM: reset beats flush, flush beats the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
        end else if (flush) begin
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_r <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && !out_xfer_s) begin
                        state_r <= ST_SKID;
                    end else if (!in_xfer_s && out_xfer_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= in_valid ? ST_FULL : ST_EMPTY;
                end
            endcase
        end
    end

    // Count stalled output cycles, sticking at all-ones; only reset clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && !flush && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load_s),
        .in_data  (main_d_data_s),
        .in_ctrl  (main_d_ctrl_s),
        .out_data (main_data_s),
        .out_ctrl (main_ctrl_s)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load_s),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_data (skid_data_s),
        .out_ctrl (skid_ctrl_s)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: the driver keeps an abstract
// model (occupancy count, FIFO of accepted entries, stall count) and the
// monitor compares DUT outputs against it on every falling edge.
module tb_pipe_stage_elastic;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int NMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t exp_q[$];
    int   occ = 0;
    int   mcnt = 0;
    bit   clean = 1'b0;
    bit   acc_last = 1'b0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the effect of the edge just taken to the abstract model.
    task automatic model_edge();
        bit ox;
        bit ix;
        acc_last = 1'b0;
        if (!rst) begin
            exp_q.delete();
            occ   = 0;
            mcnt  = 0;
            clean = 1'b1;
        end else begin
            ox = (occ > 0) && out_ready;
            ix = in_valid && (occ < 2);
            if ((occ > 0) && !out_ready && !flush)
                mcnt = (mcnt == NMAX) ? NMAX : mcnt + 1;
            if (ix) clean = 1'b0;
            if (flush) begin
                exp_q.delete();
                occ = 0;
            end else begin
                if (ox) occ--;
                if (ix) begin
                    occ++;
                    exp_q.push_back({in_data, in_ctrl});
                    acc_last = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        @(posedge clk);
        #2;
        model_edge();
    endtask

    // Monitor: compare outputs to the model, pop on an output transfer.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", 64'(in_ready), 64'(occ < 2));
            chk("out_valid", 64'(out_valid), 64'(occ > 0));
            chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
            if (occ > 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'(exp_q.size()), 64'(1));
                end else begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
                    if (out_ready && rst && !flush)
                        void'(exp_q.pop_front());
                end
            end else begin
                chk("out_ctrl_bubble", 64'(out_ctrl), 64'(0));
                if (clean) chk("out_data_reset", out_data, 64'(0));
            end
        end
    end

    logic [DW-1:0] rd;
    logic [CW-1:0] rc;
    bit            have;
    int            n;

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0);

        // Streaming 1..4 with out_ready held high
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b0, 1'b1, 64'(i), 8'(i), 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);

        // Backpressure: A loads, B goes to skid, C waits upstream
        step(1'b1, 1'b0, 1'b1, 64'hA, 8'h0A, 1'b1);
        step(1'b1, 1'b0, 1'b1, 64'hB, 8'h0B, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 64'hC, 8'h0C, 1'b0);
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, 64'hC, 8'h0C, 1'b1);
            n++;
        end while (!acc_last && n < 8);
        if (!acc_last) chk("c_accept_timeout", 64'(acc_last), 64'(1));
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);

        // Flush while in SKID, with C offered the same edge
        step(1'b1, 1'b0, 1'b1, 64'h1A, 8'h5A, 1'b1);
        step(1'b1, 1'b0, 1'b1, 64'h1B, 8'h5B, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h1C, 8'h5C, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);

        // Bubble masking of an all-ones control bundle
        step(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);

        // Reset while in SKID
        step(1'b1, 1'b0, 1'b1, 64'h2A, 8'h11, 1'b1);
        step(1'b1, 1'b0, 1'b1, 64'h2B, 8'h22, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'h2C, 8'h33, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0);

        // Counter saturation: 20 stalled cycles on a 4-bit counter
        step(1'b1, 1'b0, 1'b1, 64'h3A, 8'h44, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);

        // Randomized traffic with upstream holding an unaccepted entry
        have = 1'b0;
        rd   = 64'd0;
        rc   = 8'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!have || acc_last) begin
                have = ($urandom_range(0, 3) != 0);
                rd   = {$urandom, $urandom};
                rc   = 8'($urandom);
            end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                 have, rd, rc, ($urandom_range(0, 9) < 7));
        end

        // Drain whatever remains
        n = 0;
        while (occ > 0 && n < 10) begin
            step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);
            n++;
        end
        if (occ > 0) chk("drain_timeout", 64'(occ), 64'(0));
        step(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register for the inter-stage boundaries of the five-stage WISC core (F2D, D2X, X2M, M2W). Replaces fixed-width per-boundary flop banks with one block carrying a DATA_W-bit datapath bundle and a CTRL_W-bit control bundle under a valid/ready handshake. A two-entry (main + skid) buffer gives full throughput with a registered `in_ready`, synchronous flush for branch squash, and control-bit zeroing on bubbles so `memWrt`/`createDump`-type bits never fire from an empty slot.

## Interface
- `DATA_W`, default 64: datapath bundle width (e.g. aluOut, addPC, dataAddr, wrtData concatenated).
- `CTRL_W`, default 8: control bundle width (memWrt, readEn, createDump, wbDataSel, ...).
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset on that edge).
- `flush`  in  1  squash all held entries this edge.
- `in_valid`  in  1  upstream presents an entry.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_W  upstream datapath bundle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  main slot holds a valid entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  main slot datapath bundle.
- `out_ctrl`  out  CTRL_W  main slot control, forced 0 when `out_valid`=0.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Transfers: input when `in_valid & in_ready`; output when `out_valid & out_ready`.
- States: EMPTY (no entries), FULL (main valid), SKID (main and skid valid).
- EMPTY: `in_valid` -> FULL, main <= in.
- FULL: in xfer & out xfer -> FULL, main <= in; out xfer only -> EMPTY; in xfer only -> SKID, skid <= in; neither -> hold.
- SKID: `out_ready` -> FULL, main <= skid; else hold. No input accepted.
- `in_ready` = (state != SKID), taken from state register only; no combinational path from `out_ready` or `in_valid`.
- `out_valid` = (state != EMPTY); `out_data` = main data; `out_ctrl` = main ctrl AND {CTRL_W{out_valid}}.
- Flush (priority over handshake, below reset): next state EMPTY; held entries and any input transferred that edge are discarded; data registers may retain stale values, but `out_ctrl` reads 0 via masking.
- `stall_cnt`: +1 on each edge where `out_valid & ~out_ready` and not flush; saturates at all-ones; cleared only by reset.
- Entry order strictly preserved; skid entry always older than any later input.

## Timing
- Latency in -> out: 1 cycle (entry accepted at edge N is on `out_*` after edge N).
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- After a downstream stall begins, one further input is absorbed into skid; `in_ready` drops the following cycle.
- Reset (`rst`=0 at an edge, any state, including mid-SKID): state EMPTY, main/skid data and ctrl all 0, `stall_cnt` 0; after it `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ctrl`=0.
- `flush` and `rst` both low/high same edge: reset wins (same result).
- Flush in SKID: both entries dropped; `in_ready`=1 next cycle.

## Structure
- Shared package `pipe_pkg`: state encoding localparams ST_EMPTY=2'b00, ST_FULL=2'b01, ST_SKID=2'b10; 2'b11 is illegal and decodes to EMPTY.
- Sub-module `pipe_slot`: (DATA_W+CTRL_W)-bit register with load enable and synchronous active-low reset, built on the team `dff` cell; instantiated twice (main, skid).
- Control FSM, ready/valid decode, ctrl masking and saturating counter live in the top module.

## Test plan
- Streaming: DATA_W=64, in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready stays 1, stall_cnt=0.
- Backpressure: send A,B,C with out_ready=0 from cycle after A loads -> B lands in skid, in_ready=0 next cycle, C held upstream; release out_ready -> outputs A,B,C in order, no loss/duplication; stall_cnt equals stalled cycles.
- Flush in SKID: main=A, skid=B, assert flush with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears on output.
- Bubble masking: in_ctrl=8'hFF accepted then in_valid=0, out_ready=1 -> out_ctrl=8'hFF for one cycle, then 8'h00 with out_valid=0 despite stale data.
- Reset mid-operation: rst=0 for one edge while in SKID -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
- Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF.
